// File: rtl/jtbubl_pkg.sv
// Shared constants for the Bubble Bobble palette mixer: byte-select encoding,
// fetch FSM state encoding and transparency-nibble width.
package jtbubl_pkg;

  localparam logic BYTE_HI = 1'b1;
  localparam logic BYTE_LO = 1'b0;

  localparam int unsigned TRANSP_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_HI = 2'd1,
    RD_LO = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Two-port byte RAM, common clock. Port 0 read/write, port 1 read-only.
// Reads return the data stored before a same-clk write.
module jtframe_dual_ram #(
  parameter int unsigned dw = 8,
  parameter int unsigned aw = 10
) (
  input  logic          clk,
  input  logic [dw-1:0] data0,
  input  logic [aw-1:0] addr0,
  input  logic          we0,
  output logic [dw-1:0] q0,
  input  logic [aw-1:0] addr1,
  output logic [dw-1:0] q1
);

  logic [dw-1:0] mem [0:(2**aw)-1];

  always_ff @(posedge clk) begin
    q0 <= mem[addr0];
    q1 <= mem[addr1];
    if (we0) mem[addr0] <= data0;
  end

endmodule

// File: rtl/jtbubl_pal_mixer.sv
// Layer priority mixer with CPU-writable palette; each pixel's 16-bit entry is
// fetched as two bytes and shown one pixel-enable period after sampling.
module jtbubl_pal_mixer
  import jtbubl_pkg::*;
#(
  parameter int unsigned LAYERS = 2,
  parameter int unsigned CW     = 9,
  parameter int unsigned BPC    = 5,
  parameter int unsigned BG_COL = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pxl_cen,
  input  logic                 LHBL,
  input  logic                 LVBL,
  input  logic [LAYERS*CW-1:0] lyr_col,
  input  logic [LAYERS-1:0]    lyr_en,
  input  logic [CW:0]          cpu_addr,
  input  logic [7:0]           cpu_dout,
  input  logic                 cpu_rnw,
  input  logic                 pal_cs,
  output logic [7:0]           cpu_din,
  output logic [BPC-1:0]       red,
  output logic [BPC-1:0]       green,
  output logic [BPC-1:0]       blue
);

  localparam int unsigned EW   = 3 * BPC;
  localparam int unsigned HI_W = EW - 8;

  fetch_state_t  state, next_state;
  logic [CW-1:0] sel_col, idx;
  logic          found, vis, pend_vis, cs_d;
  logic [CW:0]   vid_addr;
  logic [7:0]    cpu_q, vid_q;
  logic [HI_W-1:0] hi;
  logic [EW-1:0] pending;

  jtframe_dual_ram #(.dw(8), .aw(CW + 1)) u_ram (
    .clk   (clk),
    .data0 (cpu_dout),
    .addr0 (cpu_addr),
    .we0   (pal_cs & ~cpu_rnw),
    .q0    (cpu_q),
    .addr1 (vid_addr),
    .q1    (vid_q)
  );

  assign cpu_din = cs_d ? cpu_q : '0;

  always_comb begin
    sel_col = CW'(BG_COL);
    found   = 1'b0;
    for (int unsigned i = 0; i < LAYERS; i++) begin
      if (!found && lyr_en[i] && lyr_col[i*CW +: TRANSP_W] != '0) begin
        sel_col = lyr_col[i*CW +: CW];
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    vid_addr   = {BYTE_LO, idx};
    case (state)
      IDLE:  next_state = IDLE;
      RD_HI: begin
        next_state = RD_LO;
        vid_addr   = {BYTE_HI, idx};
      end
      RD_LO: next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (pxl_cen) next_state = RD_HI;
  end

  // pending only changes in DONE, so an interrupted fetch leaves the last
  // complete entry (and its blank flag) for the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      vis      <= 1'b0;
      pend_vis <= 1'b0;
      pending  <= '0;
      hi       <= '0;
      cs_d     <= 1'b0;
      red      <= '0;
      green    <= '0;
      blue     <= '0;
    end else begin
      cs_d <= pal_cs;
      if (pxl_cen) begin
        idx <= sel_col;
        vis <= LHBL & LVBL;
        {red, green, blue} <= pend_vis ? pending : '0;
      end
      if (state == RD_LO) hi <= vid_q[HI_W-1:0];
      if (state == DONE) begin
        pending  <= {hi, vid_q};
        pend_vis <= vis;
      end
    end
  end

endmodule

// File: tb/tb_jtbubl_pal_mixer.sv
// Self-checking bench for jtbubl_pal_mixer: shadow palette plus a pixel-level
// model of completion, latency and blanking, checked every cycle.
module tb_jtbubl_pal_mixer;
  import jtbubl_pkg::*;

  localparam int unsigned LAYERS = 2;
  localparam int unsigned CW     = 9;
  localparam int unsigned BPC    = 5;
  localparam logic [CW-1:0] BG   = 9'h0A0;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 pxl_cen = 1'b0;
  logic                 LHBL = 1'b1;
  logic                 LVBL = 1'b1;
  logic [LAYERS*CW-1:0] lyr_col = '0;
  logic [LAYERS-1:0]    lyr_en = '0;
  logic [CW:0]          cpu_addr = '0;
  logic [7:0]           cpu_dout = '0;
  logic                 cpu_rnw = 1'b1;
  logic                 pal_cs = 1'b0;
  logic [7:0]           cpu_din;
  logic [BPC-1:0]       red, green, blue;

  jtbubl_pal_mixer #(
    .LAYERS (LAYERS),
    .CW     (CW),
    .BPC    (BPC),
    .BG_COL ('h0A0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .lyr_col  (lyr_col),
    .lyr_en   (lyr_en),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_rnw  (cpu_rnw),
    .pal_cs   (pal_cs),
    .cpu_din  (cpu_din),
    .red      (red),
    .green    (green),
    .blue     (blue)
  );

  always #5 clk = ~clk;

  int        n_chk = 0;
  int        n_fail = 0;
  logic      chk_en = 1'b0;
  logic [7:0] pal [0:1023];
  logic [14:0] exp_rgb = '0;
  logic [14:0] complete = '0;
  logic [14:0] inflight = '0;
  bit        have_prev = 1'b0;
  int        cyc = 0;
  int        last_cen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic check_rgb(input string name, input int r, input int g, input int b);
    check(name, 32'({red, green, blue}), 32'({5'(r), 5'(g), 5'(b)}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [CW-1:0] pick(input logic [LAYERS*CW-1:0] col, input logic [LAYERS-1:0] en);
    logic [CW-1:0] c;
    for (int i = 0; i < LAYERS; i++) begin
      c = col[i*CW +: CW];
      if (en[i] && (c % 16) != 0) return c;
    end
    return BG;
  endfunction

  function automatic logic [14:0] colour(input logic [CW-1:0] idx);
    logic [15:0] e;
    e = {pal[{1'b1, idx}], pal[{1'b0, idx}]};
    return e[14:0];
  endfunction

  task automatic model_reset();
    complete  = '0;
    inflight  = '0;
    have_prev = 1'b0;
    exp_rgb   = '0;
  endtask

  task automatic cpu_wr(input logic [CW:0] a, input logic [7:0] d);
    pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = a; cpu_dout = d;
    tick();
    pal_cs = 1'b0; cpu_rnw = 1'b1;
    pal[a] = d;
  endtask

  task automatic cpu_rd(input logic [CW:0] a);
    pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = a;
    tick();
    pal_cs = 1'b0;
    check("cpu_read", 32'(cpu_din), 32'(pal[a]));
  endtask

  // A fetch finishes before the next pixel enable only if they are >= 4 clk apart.
  task automatic pixel(input logic [LAYERS*CW-1:0] col, input logic [LAYERS-1:0] en,
                       input logic hb, input logic vb, input int idle);
    repeat (idle) tick();
    lyr_col = col; lyr_en = en; LHBL = hb; LVBL = vb; pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    if (have_prev && (cyc - last_cen) >= 4) complete = inflight;
    exp_rgb   = complete;
    inflight  = (hb && vb) ? colour(pick(col, en)) : '0;
    have_prev = 1'b1;
    last_cen  = cyc;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) check("pixel_stream", 32'({red, green, blue}), 32'(exp_rgb));
    end
  end

  initial begin
    logic [31:0] r;
    int idle_opts [5] = '{1, 3, 4, 5, 6};

    #2 rst_n = 1'b0;
    #1;
    check_rgb("reset_rgb", 0, 0, 0);
    check("reset_cpu_din", 32'(cpu_din), 32'h0);
    check("reset_fsm", 32'(dut.state), 32'(IDLE));
    chk_en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 1024; i++) cpu_wr(10'(i), 8'($urandom));

    // Yellow entry 0x101
    cpu_wr(10'h301, 8'h7F);
    cpu_wr(10'h101, 8'hE0);
    pixel({9'h000, 9'h101}, 2'b11, 1'b1, 1'b1, 0);
    pixel({9'h000, 9'h101}, 2'b11, 1'b1, 1'b1, 4);
    check_rgb("entry_101", 31, 31, 0);

    // Priority and enable mask
    cpu_wr(10'h212, 8'h12);
    cpu_wr(10'h012, 8'h34);
    pixel({9'h012, 9'h0F0}, 2'b11, 1'b1, 1'b1, 4);
    pixel({9'h012, 9'h101}, 2'b10, 1'b1, 1'b1, 4);
    check_rgb("layer0_transparent", 4, 17, 20);
    pixel({9'h012, 9'h101}, 2'b11, 1'b1, 1'b1, 4);
    check_rgb("layer0_disabled", 4, 17, 20);

    // Blanking
    pixel({9'h012, 9'h101}, 2'b11, 1'b1, 1'b0, 4);
    check_rgb("before_blank", 31, 31, 0);
    pixel({9'h012, 9'h101}, 2'b11, 1'b1, 1'b1, 4);
    check_rgb("blanked", 0, 0, 0);
    pixel({9'h012, 9'h101}, 2'b11, 1'b1, 1'b1, 4);
    check_rgb("unblanked", 31, 31, 0);

    // Pixel enables 2 clk apart: no fetch completes, last full entry persists
    pixel({9'h000, 9'h101}, 2'b11, 1'b1, 1'b1, 4);
    for (int i = 0; i < 12; i++) begin
      r = $urandom;
      pixel(r[17:0], r[19:18], 1'b1, 1'b1, 1);
    end
    check_rgb("fast_cen_hold", 31, 31, 0);
    pixel({9'h000, 9'h101}, 2'b11, 1'b1, 1'b1, 4);

    // Same-clk CPU write and video read of the background low byte
    cpu_wr(10'h2A0, 8'h00);
    cpu_wr(10'h0A0, 8'h11);
    pixel({9'h000, 9'h000}, 2'b00, 1'b1, 1'b1, 4);
    tick();
    cpu_wr(10'h0A0, 8'h55);
    cpu_rd(10'h0A0);
    check("rd_after_collision", 32'(cpu_din), 32'h55);
    pixel({9'h000, 9'h000}, 2'b00, 1'b1, 1'b1, 1);
    check_rgb("collision_old", 0, 0, 17);
    pixel({9'h000, 9'h000}, 2'b00, 1'b1, 1'b1, 4);
    check_rgb("collision_new", 0, 2, 21);

    // Reset during RD_LO
    pixel({9'h000, 9'h101}, 2'b11, 1'b1, 1'b1, 4);
    tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_rgb("async_reset_rgb", 0, 0, 0);
    check("async_reset_fsm", 32'(dut.state), 32'(IDLE));
    check("async_reset_cpu_din", 32'(cpu_din), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    pixel({9'h000, 9'h012}, 2'b01, 1'b1, 1'b1, 1);
    check_rgb("first_after_reset", 0, 0, 0);
    pixel({9'h000, 9'h012}, 2'b01, 1'b1, 1'b1, 4);
    check_rgb("palette_retained", 4, 17, 20);

    // Random pixels
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      pixel(r[17:0], r[19:18], r[22:20] != 3'd0, r[25:23] != 3'd0,
            idle_opts[$urandom_range(0, 4)]);
    end
    pixel('0, '0, 1'b1, 1'b1, 4);

    // Random CPU reads
    for (int i = 0; i < 40; i++) cpu_rd(10'($urandom));
    tick();
    check("cpu_din_deselected", 32'(cpu_din), 32'h0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jtbubl_pal_mixer.md
JTBUBL_PAL_MIXER -- requirements
Module: jtbubl_pal_mixer

Interface
REQ-001 Parameter LAYERS, default 2: number of colour-index layers mixed (1..4).
REQ-002 Parameter CW, default 9: colour-index width per layer; palette depth is 2^CW entries.
REQ-003 Parameter BPC, default 5: bits per output channel (4 or 5); entry bits [3*BPC-1:0] hold {R,G,B}.
REQ-004 Parameter BG_COL, default 0: colour index used when every layer is transparent.
REQ-005 clk  in  1  sole clock; CPU and video sides both run on it.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 pxl_cen  in  1  pixel clock enable, one clk wide, at least 4 clk apart.
REQ-008 LHBL, LVBL  in  1 each  active-low blanking.
REQ-009 lyr_col  in  LAYERS*CW  packed colour indexes; layer 0 occupies the LSBs.
REQ-010 lyr_en  in  LAYERS  per-layer enable mask.
REQ-011 cpu_addr  in  CW+1  palette byte address {byte_sel, index}.
REQ-012 cpu_dout  in  8  CPU write data.
REQ-013 cpu_rnw  in  1  read, not write.
REQ-014 pal_cs  in  1  palette chip select.
REQ-015 cpu_din  out  8  palette read data, valid 1 clk after the address.
REQ-016 red, green, blue  out  BPC each  registered pixel colour.

Function
REQ-017 Palette entry i occupies byte {1,i} (high byte) and byte {0,i} (low byte).
REQ-018 A CPU write shall occur on every clk where pal_cs=1 and cpu_rnw=0, with no wait states.
REQ-019 A layer shall be transparent when its lyr_en bit is 0 or its index bits [3:0] are 0.
REQ-020 At pxl_cen, the lowest-numbered non-transparent layer index shall be latched; if none qualifies, BG_COL shall be latched.
REQ-021 At the same pxl_cen, the blank flag LHBL&LVBL shall be latched alongside the index.
REQ-022 Fetch FSM states:
  - IDLE: waiting for pxl_cen.
  - RD_HI: video address {1,idx}.
  - RD_LO: video address {0,idx}; high byte captured.
  - DONE: low byte captured; assembled entry held in pending register.
  - Transitions: pxl_cen -> RD_HI -> RD_LO -> DONE -> IDLE, one clk each.
REQ-023 At each pxl_cen, red/green/blue shall load the pending entry, or 0 if its latched blank flag was 0.
REQ-024 Pixel latency shall be exactly one pxl_cen period from index sample to colour output.
REQ-025 If pxl_cen arrives before DONE, the FSM shall restart in RD_HI.
REQ-026 In that restart case, the outputs shall load the previous complete pending entry; a partial entry shall never appear.
REQ-027 A same-clk CPU write and video read of one byte shall return the old data to the video side.
REQ-028 Entry bits above 3*BPC shall be ignored.
REQ-029 cpu_din shall be 0 when pal_cs was 0 on the previous clk.

Reset
REQ-030 While rst_n=0, the following shall all be 0: red, green, blue, the pending entry, the latched index, the blank flag and cpu_din.
REQ-031 While rst_n=0, the FSM shall be in IDLE.
REQ-032 Palette contents shall not be cleared by reset.
REQ-033 Assertion of rst_n mid-fetch shall abort the fetch immediately; the first pixel after release shall output 0.

Structure
REQ-034 Byte-select encoding, FSM state encoding and the transparency-nibble width shall be constants in shared package jtbubl_pkg.
REQ-035 The palette shall be one sub-module, jtframe_dual_ram, aw=CW+1.
REQ-036 Port 0 of jtframe_dual_ram shall serve the CPU and port 1 the mixer, both clocked by clk.

Verification
REQ-037 Write 0x7F to byte 0x301 and 0xE0 to byte 0x101; drive layer0=0x101, enables=11, no blanking -> one pixel later red=31, green=31, blue=0.
REQ-038 Drive layer0=0x0F0, layer1=0x012, enables=11 -> colour of entry 0x012; with lyr_en=10 and layer1=0x012, the layer-1 colour still appears.
REQ-039 Drive LVBL=0 on a pixel whose entry is non-zero -> red=green=blue=0 exactly one pixel later; colour returns on the next unblanked pixel.
REQ-040 Space pxl_cen 2 clk apart -> no output ever shows a high byte from one entry mixed with a low byte from another.
REQ-041 CPU writes 0x55 to byte 0x0A0 on the same clk as the mixer reads it -> mixer gets old value; next pixel gets 0x55; a read of 0x0A0 one clk later gives cpu_din=0x55.
REQ-042 Pulse rst_n low during RD_LO -> outputs 0 and FSM in IDLE asynchronously; palette data is retained after release.
